// File: rtl/nabp_image_ram_scheduler.sv
// Image RAM owner for the backprojection engine.
// Each run is clear (zero-fill) -> wait for addresser -> stream PE output.
// Between runs the RAM serves host readout through a 1-cycle-latency read.
module nabp_image_ram_scheduler #(
  parameter int IMAGE_SIZE = 128,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hs_kick,
  output logic              hs_busy,
  output logic              hs_done,
  input  logic              hs_rd_req,
  input  logic [ADDR_W-1:0] hs_rd_addr,
  output logic              hs_rd_gnt,
  output logic              hs_rd_valid,
  output logic [DATA_W-1:0] hs_rd_data,
  output logic              ia_kick,
  input  logic              ia_ir_kick,
  input  logic              ia_ir_done,
  input  logic              ia_addr_valid,
  input  logic [ADDR_W-1:0] ia_addr,
  output logic              ir_enable,
  input  logic              pe_valid,
  input  logic [DATA_W-1:0] pe_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned       NPIX      = IMAGE_SIZE * IMAGE_SIZE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    BP_WAIT,
    BP_RUN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              run_write;

  // Sequencer state, clear counter and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      clr_addr    <= '0;
      hs_done     <= 1'b0;
      hs_rd_valid <= 1'b0;
      ia_kick     <= 1'b0;
    end else begin
      hs_done     <= 1'b0;
      ia_kick     <= 1'b0;
      // A read granted alongside hs_kick still returns in the first CLEAR cycle.
      hs_rd_valid <= (state == IDLE) && hs_rd_req;
      unique case (state)
        IDLE: begin
          if (hs_kick) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state   <= BP_WAIT;
            ia_kick <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        BP_WAIT: begin
          if (ia_ir_kick) state <= BP_RUN;
        end
        BP_RUN: begin
          if (ia_ir_done && pe_valid) begin
            state   <= IDLE;
            hs_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign run_write = pe_valid && ia_addr_valid;

  // RAM port mux: exactly one master per state, idle outputs forced to zero.
  always_comb begin
    hs_busy   = (state != IDLE);
    hs_rd_gnt = 1'b0;
    ir_enable = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state)
      IDLE: begin
        hs_rd_gnt = hs_rd_req;
        if (hs_rd_req) begin
          ram_en   = 1'b1;
          ram_addr = hs_rd_addr;
        end
      end
      CLEAR: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_addr;
      end
      BP_WAIT: begin
        ram_en = 1'b0;
      end
      BP_RUN: begin
        ir_enable = pe_valid;
        if (run_write) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = ia_addr;
          ram_wdata = pe_data;
        end
      end
      default: ram_en = 1'b0;
    endcase
  end

  // Read data is passed straight from the RAM during the valid cycle.
  always_comb begin
    hs_rd_data = '0;
    if (hs_rd_valid) hs_rd_data = ram_rdata;
  end

endmodule

// File: tb/tb_nabp_image_ram_scheduler.sv
// Bench for nabp_image_ram_scheduler with a 4x4 image.
module tb_nabp_image_ram_scheduler;

  localparam int IMG = 4;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int NP  = IMG * IMG;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          hs_kick = 1'b0;
  logic          hs_busy, hs_done, hs_rd_gnt, hs_rd_valid;
  logic          hs_rd_req = 1'b0;
  logic [AW-1:0] hs_rd_addr = '0;
  logic [DW-1:0] hs_rd_data;
  logic          ia_kick, ir_enable;
  logic          ia_ir_kick = 1'b0, ia_ir_done = 1'b0, ia_addr_valid = 1'b0;
  logic [AW-1:0] ia_addr = '0;
  logic          pe_valid = 1'b0;
  logic [DW-1:0] pe_data = '0;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nabp_image_ram_scheduler #(.IMAGE_SIZE(IMG), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .hs_kick(hs_kick), .hs_busy(hs_busy), .hs_done(hs_done),
    .hs_rd_req(hs_rd_req), .hs_rd_addr(hs_rd_addr), .hs_rd_gnt(hs_rd_gnt),
    .hs_rd_valid(hs_rd_valid), .hs_rd_data(hs_rd_data),
    .ia_kick(ia_kick), .ia_ir_kick(ia_ir_kick), .ia_ir_done(ia_ir_done),
    .ia_addr_valid(ia_addr_valid), .ia_addr(ia_addr), .ir_enable(ir_enable),
    .pe_valid(pe_valid), .pe_data(pe_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Single-port synchronous RAM, 1-cycle read latency.
  logic [DW-1:0] mem [NP];
  initial for (int i = 0; i < NP; i++) mem[i] = 16'hdead;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_CLEAR = 1, P_WAIT = 2, P_RUN = 3;
  int            m_phase = P_IDLE;
  int            m_cnt = 0;
  bit            m_init = 0;
  bit            m_done = 0, m_rdv = 0, m_kick = 0;
  int            m_rdaddr = 0;
  logic [DW-1:0] m_img [NP];
  bit            m_known [NP];
  initial for (int i = 0; i < NP; i++) m_known[i] = 0;

  always @(posedge clk) begin
    m_init = 1;
    if (!reset_n) begin
      m_phase = P_IDLE; m_cnt = 0;
      m_done = 0; m_rdv = 0; m_kick = 0;
    end else begin
      m_rdv    = (m_phase == P_IDLE) && hs_rd_req;
      m_rdaddr = int'(hs_rd_addr);
      m_done   = 0;
      m_kick   = 0;
      case (m_phase)
        P_IDLE: if (hs_kick) begin m_phase = P_CLEAR; m_cnt = 0; end
        P_CLEAR: begin
          m_img[m_cnt] = '0; m_known[m_cnt] = 1;
          if (m_cnt == NP - 1) begin m_phase = P_WAIT; m_kick = 1; end
          else m_cnt++;
        end
        P_WAIT: if (ia_ir_kick) m_phase = P_RUN;
        default: begin
          if (pe_valid && ia_addr_valid) begin
            m_img[int'(ia_addr)] = pe_data; m_known[int'(ia_addr)] = 1;
          end
          if (pe_valid && ia_ir_done) begin m_phase = P_IDLE; m_done = 1; end
        end
      endcase
    end
  end

  // Compare every cycle against the model, away from the clock edge.
  always @(negedge clk) begin
    logic          e_gnt, e_en, e_we, e_ir;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (m_init) begin
      e_gnt = 0; e_en = 0; e_we = 0; e_ir = 0; e_addr = '0; e_wd = '0;
      case (m_phase)
        P_IDLE:  begin e_gnt = hs_rd_req; e_en = hs_rd_req; if (hs_rd_req) e_addr = hs_rd_addr; end
        P_CLEAR: begin e_en = 1; e_we = 1; e_addr = AW'(m_cnt); end
        P_RUN: begin
          e_ir = pe_valid;
          if (pe_valid && ia_addr_valid) begin
            e_en = 1; e_we = 1; e_addr = ia_addr; e_wd = pe_data;
          end
        end
        default: ;
      endcase
      chk("busy", 32'(hs_busy), 32'(m_phase != P_IDLE));
      chk("done", 32'(hs_done), 32'(m_done));
      chk("ia_kick", 32'(ia_kick), 32'(m_kick));
      chk("rd_valid", 32'(hs_rd_valid), 32'(m_rdv));
      chk("rd_gnt", 32'(hs_rd_gnt), 32'(e_gnt));
      chk("ir_enable", 32'(ir_enable), 32'(e_ir));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
      if (!m_rdv) chk("rd_data_idle", 32'(hs_rd_data), 32'h0);
      else if (m_known[m_rdaddr]) chk("rd_data", 32'(hs_rd_data), 32'(m_img[m_rdaddr]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic neg;
    @(negedge clk);
  endtask

  int unsigned   rd_a [5] = '{5, 9, 3, 2, 15};
  logic [DW-1:0] rd_e [5] = '{16'h1234, 16'h5a5a, 16'h0000, 16'h00aa, 16'h0000};

  initial begin
    tick;
    neg;
    chk("lit_reset_busy", 32'(hs_busy), 32'h0);
    chk("lit_reset_ram_en", 32'(ram_en), 32'h0);
    chk("lit_reset_rd_data", 32'(hs_rd_data), 32'h0);
    tick;
    reset_n = 1;

    // Clear phase: 16 consecutive zero writes, kick ignored mid-clear.
    hs_kick = 1;
    tick;
    hs_kick = 0;
    for (int i = 0; i < NP; i++) begin
      hs_kick = (i == 3);
      neg;
      chk("lit_clr_addr", 32'(ram_addr), 32'(i));
      chk("lit_clr_we", 32'(ram_we), 32'h1);
      tick;
    end
    hs_kick = 1;
    neg;
    chk("lit_ia_kick_hi", 32'(ia_kick), 32'h1);
    chk("lit_wait_ram_en", 32'(ram_en), 32'h0);
    tick;
    hs_kick = 0;
    neg;
    chk("lit_ia_kick_lo", 32'(ia_kick), 32'h0);
    ia_ir_kick = 1;
    tick;
    ia_ir_kick = 0;

    // Stream: a valid write, with a host read attempt that must be refused.
    pe_valid = 1; ia_addr = 5; pe_data = 16'h1234; ia_addr_valid = 1;
    hs_rd_req = 1; hs_rd_addr = 5;
    neg;
    chk("lit_run_we", 32'(ram_we), 32'h1);
    chk("lit_run_addr", 32'(ram_addr), 32'h5);
    chk("lit_run_wdata", 32'(ram_wdata), 32'h1234);
    chk("lit_run_ir", 32'(ir_enable), 32'h1);
    chk("lit_run_gnt", 32'(hs_rd_gnt), 32'h0);
    tick;
    hs_rd_req = 0;
    pe_valid = 0;
    neg;
    chk("lit_stall_ir", 32'(ir_enable), 32'h0);
    chk("lit_stall_we", 32'(ram_we), 32'h0);
    tick;
    pe_valid = 1; ia_addr_valid = 0; ia_addr = 3; pe_data = 16'hbeef;
    neg;
    chk("lit_inv_ir", 32'(ir_enable), 32'h1);
    chk("lit_inv_we", 32'(ram_we), 32'h0);
    tick;
    ia_addr_valid = 1; ia_addr = 2; pe_data = 16'h00aa;
    tick;

    // Done while stalled must wait, then the final write completes the run.
    ia_ir_done = 1; pe_valid = 0;
    for (int i = 0; i < 3; i++) begin
      neg;
      chk("lit_done_stall_busy", 32'(hs_busy), 32'h1);
      tick;
    end
    pe_valid = 1; ia_addr = 9; pe_data = 16'h5a5a;
    neg;
    chk("lit_last_we", 32'(ram_we), 32'h1);
    tick;
    pe_valid = 0; ia_ir_done = 0; ia_addr_valid = 0; ia_addr = 0; pe_data = 0;
    neg;
    chk("lit_hs_done", 32'(hs_done), 32'h1);
    chk("lit_idle_busy", 32'(hs_busy), 32'h0);
    tick;
    neg;
    chk("lit_hs_done_lo", 32'(hs_done), 32'h0);

    // Readout of written, suppressed and cleared pixels.
    for (int k = 0; k < 5; k++) begin
      hs_rd_req = 1; hs_rd_addr = AW'(rd_a[k]);
      neg;
      chk("lit_rd_gnt", 32'(hs_rd_gnt), 32'h1);
      tick;
      hs_rd_req = 0;
      neg;
      chk("lit_rd_valid", 32'(hs_rd_valid), 32'h1);
      chk("lit_rd_data", 32'(hs_rd_data), 32'(rd_e[k]));
      tick;
    end

    // Read granted with hs_kick returns in the first CLEAR cycle.
    hs_rd_req = 1; hs_rd_addr = 9; hs_kick = 1;
    tick;
    hs_rd_req = 0; hs_kick = 0;
    neg;
    chk("lit_kick_rd_data", 32'(hs_rd_data), 32'h5a5a);
    chk("lit_kick_clr0", 32'(ram_addr), 32'h0);
    repeat (7) tick;
    neg;
    chk("lit_clr7", 32'(ram_addr), 32'h7);

    // Reset mid-clear: idle next cycle, no done pulse, fresh clear from 0.
    reset_n = 0;
    tick;
    reset_n = 1;
    neg;
    chk("lit_rst_busy", 32'(hs_busy), 32'h0);
    chk("lit_rst_done", 32'(hs_done), 32'h0);
    tick;
    neg;
    chk("lit_rst_done2", 32'(hs_done), 32'h0);
    hs_kick = 1;
    tick;
    hs_kick = 0;
    neg;
    chk("lit_reclr_addr", 32'(ram_addr), 32'h0);
    chk("lit_reclr_we", 32'(ram_we), 32'h1);
    repeat (NP) tick;
    neg;
    chk("lit_reclr_ia_kick", 32'(ia_kick), 32'h1);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
